// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module  : uart_pkg
// Brief   : Shared UART types, constants and the tick divider helper.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Clocks per oversample tick; integer division truncates.
    function automatic int uart_div(input int clk, input int baud, input int os);
        return clk / (baud * os);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
//------------------------------------------------------------------------------
// Module  : uart_rx_fifo
// Brief   : Show-ahead byte FIFO with overrun pulse; simultaneous push/pop
//           always succeeds, even when full.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = DATA_BITS
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr;
    logic [c_aw:0]    r_rd;
    logic             r_overrun;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit distinguishes full from empty; rollover wraps naturally.
    assign count   = r_wr - r_rd;
    assign empty   = (count == '0);
    assign full    = (count == (c_aw + 1)'(DEPTH));
    assign dout    = empty ? '0 : r_mem[r_rd[c_aw-1:0]];
    assign overrun = r_overrun;

    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            r_overrun <= push & full & ~pop;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_do_push) r_mem[r_wr[c_aw-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_buffered.sv
//------------------------------------------------------------------------------
// Module  : uart_rx_buffered
// Brief   : 16x-oversampled UART receiver feeding a show-ahead byte FIFO with
//           rdy/dout/rdy_clr read handshake. Define UART_RX_PARITY_EN for
//           8E1 frames (even parity); default build is 8N1.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          dout,
    output logic                          rdy,
    input  logic                          rdy_clr,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          parity_err
);

    localparam int c_div = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int c_tw  = (c_div > 1) ? $clog2(c_div) : 1;
    localparam int c_sw  = $clog2(OVERSAMPLE);

    localparam logic [c_tw-1:0] c_tick_last = c_tw'(c_div - 1);
    localparam logic [c_sw-1:0] c_s_half    = c_sw'(OVERSAMPLE / 2 - 1);
    localparam logic [c_sw-1:0] c_s_last    = c_sw'(OVERSAMPLE - 1);
    localparam logic [2:0]      c_bit_last  = 3'(DATA_BITS - 1);

    logic                  r_rx_meta;
    logic                  r_rx_sync;
    logic [1:0]            r_prime;
    logic                  r_armed;
    logic [c_tw-1:0]       r_tick_cnt;
    logic                  w_tick;

    rx_state_e             r_state,   w_state_n;
    logic [c_sw-1:0]       r_s,       w_s_n;
    logic [2:0]            r_bit,     w_bit_n;
    logic [DATA_BITS-1:0]  r_shift,   w_shift_n;
    logic                  w_push;
    logic                  w_ferr;
    logic                  w_perr;

    logic                  r_push;
    logic [DATA_BITS-1:0]  r_push_data;
    logic                  r_frame_err;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic                  w_unused_ok;

    // A line held low through reset release must go high before a start counts.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_prime   <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_prime   <= {r_prime[0], 1'b1};
            if (r_prime[1] && r_rx_sync) r_armed <= 1'b1;
        end
    end

    assign w_tick = (r_tick_cnt == c_tick_last);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_tick_cnt <= '0;
        else        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad, w_par_bad_n;
    logic r_parity_err;
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= IDLE;
            r_s         <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_n;
            r_s         <= w_s_n;
            r_bit       <= w_bit_n;
            r_shift     <= w_shift_n;
            r_push      <= w_push;
            r_frame_err <= w_ferr;
            if (w_push) r_push_data <= r_shift;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= w_par_bad_n;
            r_parity_err <= w_perr;
`endif
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_s_n     = r_s;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_push    = 1'b0;
        w_ferr    = 1'b0;
        w_perr    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_n = r_par_bad;
`endif
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (r_armed && !r_rx_sync) begin
                        w_state_n = START;
                        w_s_n     = '0;
                    end
                end
                START: begin
                    if (r_s == c_s_half) begin
                        w_s_n   = '0;
                        w_bit_n = '0;
                        w_state_n = r_rx_sync ? IDLE : DATA;
                    end else begin
                        w_s_n = r_s + 1'b1;
                    end
                end
                DATA: begin
                    if (r_s == c_s_last) begin
                        w_s_n     = '0;
                        w_shift_n = {r_rx_sync, r_shift[DATA_BITS-1:1]};
                        w_bit_n   = r_bit + 3'd1;
                        if (r_bit == c_bit_last) begin
`ifdef UART_RX_PARITY_EN
                            w_state_n = PARITY;
`else
                            w_state_n = STOP;
`endif
                        end
                    end else begin
                        w_s_n = r_s + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (r_s == c_s_last) begin
                        w_s_n       = '0;
                        w_par_bad_n = r_rx_sync ^ (^r_shift);
                        w_state_n   = STOP;
                    end else begin
                        w_s_n = r_s + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // Leaving at mid-stop keeps back-to-back frames aligned.
                    if (r_s == c_s_last) begin
                        w_s_n     = '0;
                        w_state_n = IDLE;
                        w_ferr    = ~r_rx_sync;
`ifdef UART_RX_PARITY_EN
                        w_perr    = r_par_bad;
                        w_push    = r_rx_sync & ~r_par_bad;
`else
                        w_push    = r_rx_sync;
`endif
                    end else begin
                        w_s_n = r_s + 1'b1;
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    assign frame_err   = r_frame_err;
    assign rdy         = ~w_fifo_empty;
    assign w_unused_ok = w_fifo_full | w_perr;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .push    (r_push),
        .din     (r_push_data),
        .pop     (rdy_clr),
        .dout    (dout),
        .empty   (w_fifo_empty),
        .full    (w_fifo_full),
        .count   (count),
        .overrun (overrun)
    );

endmodule

`default_nettype wire
